pipe_stage_chain: RTL and testbench
===================================

// Module: pipe_stage_chain
// PURPOSE
// Parametrised chain of pipeline registers with per-stage valid bits, stall
// back-propagation and per-stage flush. Generic IF/ID/EX/MEM/WB-style stage
// register fabric for the core and for multi-cycle units (e.g. mul/div
// writeback). Replaces fixed global StallX/FlushX wiring with a ready/valid
// chain. Optional bubble-collapse lets stalled pipes absorb holes.
// PARAMETERS
// STAGES           4   number of register stages (>=1); stage STAGES-1 drives output
// WIDTH            32  payload width in bits
// BUBBLE_COLLAPSE  1   1: stage advances into an empty successor while the tail
//                      is stalled; 0: one uniform stall for all stages
// PORTS
// clk          in   1                  clock, all state on rising edge
// reset        in   1                  asynchronous, active-high; clears all state
// in_valid     in   1                  upstream offers in_data
// in_ready     out  1                  stage 0 can accept this cycle
// in_data      in   WIDTH              payload entering stage 0
// out_valid    out  1                  stage STAGES-1 holds a valid item
// out_ready    in   1                  downstream consumes out_data this cycle
// out_data     out  WIDTH              payload of stage STAGES-1
// flush_mask   in   STAGES             bit i=1: kill stage i contents at next edge
// stage_valid  out  STAGES             valid bit per stage (hazard-unit visibility)
// occupancy    out  $clog2(STAGES+1)   popcount of stage_valid
// BEHAVIOUR
// - Reset (async, any time): all valid_q=0, all data_q=0; so out_valid=0,
//   out_data=0, stage_valid=0, occupancy=0, in_ready=1 combinationally.
// - ready[S-1] = out_ready | ~valid_q[S-1].
// - BUBBLE_COLLAPSE=1: ready[i] = ready[i+1] | ~valid_q[i], i<S-1.
//   BUBBLE_COLLAPSE=0: ready[i] = ready[S-1] for all i (global stall).
// - in_ready = ready[0]; purely combinational, no dependence on in_valid.
// - Edge update, stage i (src = in_valid/in_data for i=0, else stage i-1):
//   flush_mask[i]=1        -> valid_q[i]<=0 (highest priority; data don't-care)
//   else ready[i]=1        -> valid_q[i]<=src_valid, data_q[i]<=src_data
//   else                   -> hold valid_q[i] and data_q[i]
// - data_q may load garbage when src invalid; only valid-qualified data checked.
// - Transfer in: in_valid & in_ready. If flush_mask[0] same cycle, item is
//   consumed upstream and dropped (FlushD semantics).
// - Transfer out: out_valid & out_ready; item leaves stage S-1 at that edge.
// - Latency: accepted item at edge t is at out_data after edge t+S-1, i.e.
//   visible S-1 cycles after acceptance cycle; no stalls -> throughput 1/cycle.
// - Stability: while out_valid=1 and out_ready=0, out_data holds; out_valid
//   drops only via flush_mask[S-1] (deliberate exception to strict AXI rule).
// - Ordering: items leave in acceptance order; never duplicated; lost only via flush.
// - Flush + stall on same stage: flush wins. Flush of stage i does not stall
//   or flush neighbours; stage i+1 may load the killed item only in the same
//   edge it advanced (it left before kill) - normal advance semantics.
// - STAGES=1: single register, ready[0]=out_ready|~valid_q[0].
// - occupancy and stage_valid reflect registered state only (no comb. path).
// TESTING (STAGES=4, WIDTH=32 unless noted)
// 1 Reset, out_ready=1, stream 0x1..0x8 back-to-back -> in_ready always 1,
//   out_valid first high 3 cycles after first accept, outputs 0x1..0x8 in order.
// 2 out_ready=0, offer 6 items -> 4 accepted, in_ready=0, occupancy=4,
//   out_data=0x1 stable; release out_ready -> 0x1..0x6 delivered, no loss/dup.
// 3 out_ready=0; A at cycle 0, idle 2 cycles, B at cycle 3: COLLAPSE=1 -> B
//   reaches stage 2, in_ready=1, occupancy=2; COLLAPSE=0 -> B held in stage 0,
//   in_ready=0.
// 4 Stages 0..3 hold 5,4,3,2; flush_mask=4'b0011 one cycle, out_ready=1 ->
//   2,3 delivered, 4,5 never appear, occupancy drops by 2 plus drain.
// 5 out_ready=0, stage 3 valid, flush_mask=4'b1000 -> out_valid=0 next
//   cycle, stage 2 item advances into stage 3 the following edge.
// 6 Assert reset between edges mid-stream -> out_valid, occupancy, stage_valid
//   go 0 immediately; after release, next accepted item emerges after 3 cycles.

Source files
------------

// File: rtl/pipe_stage_chain.sv
// Ready/valid pipeline register chain with per-stage flush
// and optional bubble collapse behind a stalled tail.
module pipe_stage_chain #(
  parameter int STAGES          = 4,
  parameter int WIDTH           = 32,
  parameter bit BUBBLE_COLLAPSE = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  input  logic [STAGES-1:0]            flush_mask,
  output logic [STAGES-1:0]            stage_valid,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);

  localparam int OW = $clog2(STAGES + 1);

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] ready;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] src_v;
  logic [WIDTH-1:0]  src_d  [STAGES];

  // A stage may load when anything at or after it has a hole,
  // or when the whole chain drains through the tail.
  always_comb begin
    logic r;
    r     = out_ready | ~valid_q[STAGES-1];
    ready = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (BUBBLE_COLLAPSE) r = r | ~valid_q[i];
      ready[i] = r;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic             v_q;
    logic [WIDTH-1:0] d_q;

    if (i == 0) begin : g_head
      assign src_v[i] = in_valid;
      assign src_d[i] = in_data;
    end else begin : g_body
      assign src_v[i] = valid_q[i-1];
      assign src_d[i] = data_q[i-1];
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        v_q <= 1'b0;
        d_q <= '0;
      end else if (flush_mask[i]) begin
        v_q <= 1'b0;
      end else if (ready[i]) begin
        v_q <= src_v[i];
        d_q <= src_d[i];
      end
    end

    assign valid_q[i] = v_q;
    assign data_q[i]  = d_q;
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++)
      occupancy = occupancy + OW'(valid_q[i]);
  end

  assign in_ready    = ready[0];
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign stage_valid = valid_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: collapse and global-stall variants
// driven side by side against a slot-level reference model.
module tb_pipe_stage_chain;

  localparam int S = 4;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_ready;
  logic [S-1:0] flush_mask;

  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [S-1:0] stage_valid;
  logic [2:0]   occupancy;

  logic         in_ready_g, out_valid_g;
  logic [W-1:0] out_data_g;
  logic [S-1:0] stage_valid_g;
  logic [2:0]   occupancy_g;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.STAGES(S), .WIDTH(W), .BUBBLE_COLLAPSE(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush_mask(flush_mask), .stage_valid(stage_valid),
    .occupancy(occupancy)
  );

  pipe_stage_chain #(.STAGES(S), .WIDTH(W), .BUBBLE_COLLAPSE(1'b0)) dut_g (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_g), .in_data(in_data),
    .out_valid(out_valid_g), .out_ready(out_ready), .out_data(out_data_g),
    .flush_mask(flush_mask), .stage_valid(stage_valid_g),
    .occupancy(occupancy_g)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k=0 collapsing chain, k=1 global stall.
  typedef struct {
    bit          v;
    logic [31:0] d;
  } slot_t;

  slot_t m [2][S];

  function automatic bit m_loads(int k, int i, bit ordy);
    bit f;
    f = !m[k][S-1].v || ordy;
    if (k == 0)
      for (int j = S - 2; j >= i; j--) f = f || !m[k][j].v;
    return f;
  endfunction

  task automatic m_clear();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < S; i++) m[k][i] = '{1'b0, 32'h0};
  endtask

  task automatic m_step(bit iv, logic [31:0] id, bit ordy, logic [S-1:0] fl);
    slot_t src [S];
    slot_t nx  [S];
    bit    ld  [S];
    for (int k = 0; k < 2; k++) begin
      src[0] = '{iv, id};
      for (int i = 1; i < S; i++) src[i] = m[k][i-1];
      for (int i = 0; i < S; i++) ld[i] = m_loads(k, i, ordy);
      for (int i = 0; i < S; i++) begin
        if (fl[i])      nx[i] = '{1'b0, m[k][i].d};
        else if (ld[i]) nx[i] = src[i];
        else            nx[i] = m[k][i];
      end
      for (int i = 0; i < S; i++) m[k][i] = nx[i];
    end
  endtask

  task automatic cmp_model(int k, string tag, logic ov, logic [31:0] od,
                           logic ir, logic [S-1:0] sv, logic [2:0] occ);
    logic [S-1:0] esv;
    int           eocc;
    eocc = 0;
    for (int i = 0; i < S; i++) begin
      esv[i] = m[k][i].v;
      eocc  += int'(m[k][i].v);
    end
    chk({tag, " out_valid"}, 32'(ov), 32'(m[k][S-1].v));
    if (m[k][S-1].v) chk({tag, " out_data"}, od, m[k][S-1].d);
    chk({tag, " in_ready"}, 32'(ir), 32'(m_loads(k, 0, out_ready)));
    chk({tag, " stage_valid"}, 32'(sv), 32'(esv));
    chk({tag, " occupancy"}, 32'(occ), 32'(eocc));
  endtask

  // Inputs are already set; compare with the model, then clock it.
  task automatic tick();
    #1;
    cmp_model(0, "model_c", out_valid, out_data, in_ready,
              stage_valid, occupancy);
    cmp_model(1, "model_g", out_valid_g, out_data_g, in_ready_g,
              stage_valid_g, occupancy_g);
    @(posedge clk);
    m_step(in_valid, in_data, out_ready, flush_mask);
    #1;
  endtask

  task automatic do_reset();
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    flush_mask = '0;
    reset      = 1'b1;
    #1;
    reset = 1'b0;
    m_clear();
  endtask

  // Stalled fill: items base..base+n-1, all accepted.
  task automatic fill(int n, int base);
    out_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 32'(base + i);
      tick();
    end
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic [3:0]  fl;
    logic        ov;
    logic [31:0] od;
    logic        ir;
    logic [2:0]  occ;
  } vec_t;

  vec_t        vecs [13];
  logic [31:0] got  [$];
  logic [31:0] got_g[$];
  logic [31:0] exp_q[$];
  int          nxt, lat;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    m_clear();
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    flush_mask = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_data", out_data, 0);
    chk("rst stage_valid", 32'(stage_valid), 0);
    chk("rst occupancy", 32'(occupancy), 0);
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst in_ready_g", 32'(in_ready_g), 1);
    reset = 1'b0;

    // 1: back-to-back stream 0x1..0x8
    vecs[0]  = '{1, 1, 1, 0, 0, 0, 1, 0};
    vecs[1]  = '{1, 2, 1, 0, 0, 0, 1, 1};
    vecs[2]  = '{1, 3, 1, 0, 0, 0, 1, 2};
    vecs[3]  = '{1, 4, 1, 0, 0, 0, 1, 3};
    vecs[4]  = '{1, 5, 1, 0, 1, 1, 1, 4};
    vecs[5]  = '{1, 6, 1, 0, 1, 2, 1, 4};
    vecs[6]  = '{1, 7, 1, 0, 1, 3, 1, 4};
    vecs[7]  = '{1, 8, 1, 0, 1, 4, 1, 4};
    vecs[8]  = '{0, 0, 1, 0, 1, 5, 1, 4};
    vecs[9]  = '{0, 0, 1, 0, 1, 6, 1, 3};
    vecs[10] = '{0, 0, 1, 0, 1, 7, 1, 2};
    vecs[11] = '{0, 0, 1, 0, 1, 8, 1, 1};
    vecs[12] = '{0, 0, 1, 0, 0, 0, 1, 0};
    for (int c = 0; c < 13; c++) begin
      in_valid   = vecs[c].iv;
      in_data    = vecs[c].id;
      out_ready  = vecs[c].ordy;
      flush_mask = vecs[c].fl;
      #1;
      chk("t1 out_valid", 32'(out_valid), 32'(vecs[c].ov));
      chk("t1g out_valid", 32'(out_valid_g), 32'(vecs[c].ov));
      if (vecs[c].ov) begin
        chk("t1 out_data", out_data, vecs[c].od);
        chk("t1g out_data", out_data_g, vecs[c].od);
      end
      chk("t1 in_ready", 32'(in_ready), 32'(vecs[c].ir));
      chk("t1 occupancy", 32'(occupancy), 32'(vecs[c].occ));
      tick();
    end

    // 2: stalled tail, six offers, then release
    do_reset();
    nxt = 1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1;
      in_data  = 32'(nxt);
      #1;
      if (out_valid) chk("t2 out_data hold", out_data, 1);
      if (in_ready) nxt++;
      tick();
    end
    chk("t2 accepted", 32'(nxt - 1), 4);
    chk("t2 in_ready", 32'(in_ready), 0);
    chk("t2 occupancy", 32'(occupancy), 4);
    chk("t2 out_data", out_data, 1);
    got.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (nxt <= 6);
      in_data  = 32'(nxt);
      #1;
      if (out_valid) got.push_back(out_data);
      if (in_valid && in_ready) nxt++;
      tick();
    end
    chk("t2 delivered", 32'(got.size()), 6);
    for (int i = 0; i < got.size() && i < 6; i++)
      chk("t2 order", got[i], 32'(i + 1));

    // 3: hole absorption behind a stalled tail
    do_reset();
    in_valid = 1'b1; in_data = 32'hA; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1; in_data = 32'hB; tick();
    in_valid = 1'b0; tick(); tick();
    #1;
    chk("t3 stage_valid", 32'(stage_valid), 32'b1100);
    chk("t3 in_ready", 32'(in_ready), 1);
    chk("t3 occupancy", 32'(occupancy), 2);
    chk("t3g stage_valid", 32'(stage_valid_g), 32'b1001);
    chk("t3g in_ready", 32'(in_ready_g), 0);
    chk("t3g occupancy", 32'(occupancy_g), 2);
    chk("t3 out_data", out_data, 32'hA);
    tick();

    // 4a: flush stages 0,1 while stalled, then drain
    do_reset();
    fill(4, 2);
    #1;
    chk("t4a occupancy", 32'(occupancy), 4);
    flush_mask = 4'b0011;
    tick();
    flush_mask = '0;
    #1;
    chk("t4a occ after", 32'(occupancy), 2);
    chk("t4a stage_valid", 32'(stage_valid), 32'b1100);
    got.delete(); got_g.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) got.push_back(out_data);
      if (out_valid_g) got_g.push_back(out_data_g);
      tick();
    end
    exp_q = '{32'd2, 32'd3};
    chk("t4a count", 32'(got.size()), 2);
    chk("t4a count_g", 32'(got_g.size()), 2);
    for (int i = 0; i < got.size() && i < 2; i++) chk("t4a data", got[i], exp_q[i]);
    for (int i = 0; i < got_g.size() && i < 2; i++) chk("t4a data_g", got_g[i], exp_q[i]);

    // 4b: same flush while flowing; stage 1 item advances before the kill
    do_reset();
    fill(4, 2);
    got.delete();
    out_ready  = 1'b1;
    flush_mask = 4'b0011;
    for (int c = 0; c < 7; c++) begin
      #1;
      if (out_valid) got.push_back(out_data);
      tick();
      flush_mask = '0;
    end
    exp_q = '{32'd2, 32'd3, 32'd4};
    chk("t4b count", 32'(got.size()), 3);
    for (int i = 0; i < got.size() && i < 3; i++) chk("t4b data", got[i], exp_q[i]);

    // 5: flush the stalled tail; stage 2 moves up next edge
    do_reset();
    fill(4, 1);
    flush_mask = 4'b1000;
    tick();
    flush_mask = '0;
    #1;
    chk("t5 out_valid", 32'(out_valid), 0);
    chk("t5g out_valid", 32'(out_valid_g), 0);
    chk("t5 in_ready", 32'(in_ready), 1);
    tick();
    #1;
    chk("t5 out_valid next", 32'(out_valid), 1);
    chk("t5 out_data next", out_data, 2);
    chk("t5g out_data next", out_data_g, 2);
    chk("t5 occupancy", 32'(occupancy), 3);

    // 6: async reset between edges
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i + 1); tick();
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("t6 out_valid", 32'(out_valid), 0);
    chk("t6 occupancy", 32'(occupancy), 0);
    chk("t6 stage_valid", 32'(stage_valid), 0);
    chk("t6 in_ready", 32'(in_ready), 1);
    chk("t6g stage_valid", 32'(stage_valid_g), 0);
    reset = 1'b0;
    m_clear();
    in_valid = 1'b1; in_data = 32'h77;
    tick();
    in_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 8; c++) begin
      #1;
      if (out_valid && lat == 0) begin
        lat = c;
        chk("t6 data", out_data, 32'h77);
      end
      tick();
    end
    chk("t6 latency", 32'(lat), 4);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      in_valid   = ($urandom % 4) != 0;
      in_data    = $urandom;
      out_ready  = ($urandom % 10) < 6;
      flush_mask = (($urandom % 10) == 0) ? 4'($urandom) : 4'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
